// File: rtl/lcb_distributor_n_pkg.sv
// Shared definitions for the N-channel LCB memory-port distributor:
// state encoding, width helper and the default word widths used by memGrp/lcbFull.
package lcb_distributor_n_pkg;

  localparam int LCB_AW = 10;
  localparam int LCB_DW = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } lcbState_e;

  // Never narrower than one bit, so a two-channel pointer still has a register.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/lcb_distributor_n_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after the pointer,
// wrapping modulo NCH, returned both one-hot and as an index.
module lcb_rr_arbiter
  import lcb_distributor_n_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = clog2(NCH)
) (
  input  logic [NCH-1:0] eligible_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] grantOneHot_o,
  output logic [PW-1:0]  grantIdx_o,
  output logic           valid_o
);

  always_comb begin
    int cand;
    logic [PW-1:0] candIdx;
    grantOneHot_o = '0;
    grantIdx_o    = '0;
    valid_o       = 1'b0;
    cand          = 0;
    candIdx       = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NCH) cand = cand - NCH;
      candIdx = PW'(cand);
      if (!valid_o && eligible_i[candIdx]) begin
        valid_o                = 1'b1;
        grantOneHot_o[candIdx] = 1'b1;
        grantIdx_o             = candIdx;
      end
    end
  end

endmodule

// File: rtl/lcb_distributor_n.sv
// Shares one LCB memory write/old-word read path among NCH lcbFull receivers with
// round-robin ownership, a one-cycle guard gap and a hold-time watchdog.
module lcb_distributor_n
  import lcb_distributor_n_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int AW       = LCB_AW,
  parameter int DW       = LCB_DW,
  parameter int MAX_HOLD = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NCH-1:0]    busy_i,
  output logic [NCH-1:0]    grant_o,
  input  logic [NCH*DW-1:0] wrdOut_i,
  input  logic [NCH*AW-1:0] wrdAddr_i,
  input  logic [NCH-1:0]    wren_i,
  input  logic [NCH*AW-1:0] oldWrdAddr_i,
  input  logic [NCH-1:0]    oldRdEn_i,
  output logic [NCH*DW-1:0] oldWrd_o,
  output logic [DW-1:0]     commWrdOut_o,
  output logic [AW-1:0]     commWrdAddr_o,
  output logic              commWren_o,
  output logic [AW-1:0]     commOldWrdAddr_o,
  output logic              commOldRdEn_o,
  input  logic [DW-1:0]     commOldWrd_i,
  output logic [NCH-1:0]    holdErr_o,
  output logic [NCH-1:0]    dropErr_o,
  input  logic              clrErr_i
);

  localparam int PW = clog2(NCH);
  localparam int CW = clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NCH - 1);

  lcbState_e      state_q;
  logic [NCH-1:0] grant_q, grantPrev_q;
  logic [NCH-1:0] blocked_q, blocked_d;
  logic [NCH-1:0] holdErr_q, holdErr_d;
  logic [NCH-1:0] dropErr_q, dropErr_d;
  logic [PW-1:0]  owner_q, ptr_q;
  logic [CW-1:0]  holdCnt_q;

  logic [NCH-1:0] eligible, arbOneHot, holdSet, dropSet;
  logic [PW-1:0]  arbIdx;
  logic           arbValid, ownerBusy, holdExpire;

  // A watchdog-released channel stays out of arbitration until its busy drops.
  assign eligible   = busy_i & ~blocked_q;
  assign ownerBusy  = busy_i[owner_q];
  assign holdExpire = (state_q == OWN) && ownerBusy && (holdCnt_q == HOLD_LAST);
  assign holdSet    = holdExpire ? grant_q : '0;
  assign dropSet    = wren_i & ~(grant_q | grantPrev_q);

  lcb_rr_arbiter #(
    .NCH (NCH),
    .PW  (PW)
  ) u_arbiter (
    .eligible_i    (eligible),
    .ptr_i         (ptr_q),
    .grantOneHot_o (arbOneHot),
    .grantIdx_o    (arbIdx),
    .valid_o       (arbValid)
  );

  always_comb begin
    blocked_d = (blocked_q & busy_i) | holdSet;
    holdErr_d = (clrErr_i ? '0 : holdErr_q) | holdSet;
    dropErr_d = (clrErr_i ? '0 : dropErr_q) | dropSet;
  end

  // GAP doubles as an arbitration cycle so back-to-back owners see one dead cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      holdCnt_q <= '0;
    end else begin
      case (state_q)
        OWN: begin
          if (!ownerBusy || holdExpire) begin
            state_q   <= GAP;
            grant_q   <= '0;
            holdCnt_q <= '0;
          end else begin
            holdCnt_q <= holdCnt_q + CW'(1);
          end
        end
        IDLE, GAP: begin
          holdCnt_q <= '0;
          if (arbValid) begin
            state_q <= OWN;
            grant_q <= arbOneHot;
            owner_q <= arbIdx;
            ptr_q   <= (arbIdx == PTR_LAST) ? '0 : arbIdx + PW'(1);
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          grant_q   <= '0;
          holdCnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grantPrev_q <= '0;
      blocked_q   <= '0;
      holdErr_q   <= '0;
      dropErr_q   <= '0;
    end else begin
      grantPrev_q <= grant_q;
      blocked_q   <= blocked_d;
      holdErr_q   <= holdErr_d;
      dropErr_q   <= dropErr_d;
    end
  end

  // Only the registered owner reaches the memory port; everything else reads as zero.
  always_comb begin
    commWrdOut_o     = '0;
    commWrdAddr_o    = '0;
    commWren_o       = 1'b0;
    commOldWrdAddr_o = '0;
    commOldRdEn_o    = 1'b0;
    oldWrd_o         = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_q[i]) begin
        commWrdOut_o           = wrdOut_i[i*DW +: DW];
        commWrdAddr_o          = wrdAddr_i[i*AW +: AW];
        commWren_o             = wren_i[i];
        commOldWrdAddr_o       = oldWrdAddr_i[i*AW +: AW];
        commOldRdEn_o          = oldRdEn_i[i];
        oldWrd_o[i*DW +: DW]   = commOldWrd_i;
      end
    end
  end

  assign grant_o   = grant_q;
  assign holdErr_o = holdErr_q;
  assign dropErr_o = dropErr_q;

endmodule
